// File: rtl/enc16to4_stream.sv
// enc16to4_stream: sequential 16-to-4 encoder.
// Takes a 16-line vector and emits the 4-bit index of each set line, one per
// out_valid/out_ready handshake, lowest-first (MSB_FIRST=0) or highest-first
// (MSB_FIRST=1). An all-zero vector is reported by a one-cycle zero_err pulse.
module enc16to4_stream #(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] in_vec,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [3:0]  out_code,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic [4:0]  bit_count,
  output logic        zero_err
);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t      state_reg, state_next;
  logic [15:0] pending_reg, pending_next;
  logic [4:0]  bit_count_reg, bit_count_next;
  logic        zero_err_reg, zero_err_next;

  // pending re-ordered so that the next line to emit is always the lowest set bit
  logic [15:0] ordered;
  logic [3:0]  ordered_idx;
  logic [3:0]  sel_code;
  logic        single_bit;
  logic [4:0]  load_count;

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_order
      assign ordered[gi] = MSB_FIRST ? pending_reg[15 - gi] : pending_reg[gi];
    end
  endgenerate

  // Find the lowest set bit of the re-ordered vector
  always_comb begin
    ordered_idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (ordered[i]) ordered_idx = 4'(i);
    end
  end

  assign sel_code   = MSB_FIRST ? (4'd15 - ordered_idx) : ordered_idx;
  assign single_bit = (pending_reg & (pending_reg - 16'd1)) == 16'd0;

  // Popcount of the incoming vector, captured at acceptance
  always_comb begin
    load_count = 5'd0;
    for (int i = 0; i < 16; i++) begin
      load_count = load_count + {4'd0, in_vec[i]};
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == EMIT);
  assign out_code  = out_valid ? sel_code : 4'd0;
  assign out_last  = out_valid && single_bit;
  assign bit_count = bit_count_reg;
  assign zero_err  = zero_err_reg;

  // Next-state logic: load in IDLE, retire one line per handshake in EMIT
  always_comb begin
    state_next     = state_reg;
    pending_next   = pending_reg;
    bit_count_next = bit_count_reg;
    zero_err_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          if (in_vec != 16'd0) begin
            pending_next   = in_vec;
            bit_count_next = load_count;
            state_next     = EMIT;
          end else begin
            bit_count_next = 5'd0;
            zero_err_next  = 1'b1;
          end
        end
      end
      EMIT: begin
        if (out_ready) begin
          if (single_bit) begin
            pending_next = 16'd0;
            state_next   = IDLE;
          end else begin
            pending_next = pending_reg & ~(16'd1 << sel_code);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State registers; reset discards any pending lines immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      pending_reg   <= 16'd0;
      bit_count_reg <= 5'd0;
      zero_err_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      pending_reg   <= pending_next;
      bit_count_reg <= bit_count_next;
      zero_err_reg  <= zero_err_next;
    end
  end

endmodule

// File: tb/tb_enc16to4_stream.sv
// Testbench for enc16to4_stream: one instance per priority order, shared stimulus.
module tb_enc16to4_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in_vec;
  logic        in_valid;
  logic        out_ready;

  logic        in_ready0, in_ready1;
  logic [3:0]  out_code0, out_code1;
  logic        out_valid0, out_valid1;
  logic        out_last0, out_last1;
  logic [4:0]  bit_count0, bit_count1;
  logic        zero_err0, zero_err1;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  enc16to4_stream #(.MSB_FIRST(1'b0)) dut0 (
    .clk(clk), .rst(rst), .in_vec(in_vec), .in_valid(in_valid), .in_ready(in_ready0),
    .out_code(out_code0), .out_valid(out_valid0), .out_ready(out_ready),
    .out_last(out_last0), .bit_count(bit_count0), .zero_err(zero_err0)
  );

  enc16to4_stream #(.MSB_FIRST(1'b1)) dut1 (
    .clk(clk), .rst(rst), .in_vec(in_vec), .in_valid(in_valid), .in_ready(in_ready1),
    .out_code(out_code1), .out_valid(out_valid1), .out_ready(out_ready),
    .out_last(out_last1), .bit_count(bit_count1), .zero_err(zero_err1)
  );

  typedef struct {
    logic [15:0] vec;
    int          exp_cnt;
    int          exp_first_lsb;
    int          exp_first_msb;
    int          stall_first;
  } vec_rec_t;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_idle(input int exp_cnt);
    check("idle_ready0", int'(in_ready0), 1);
    check("idle_ready1", int'(in_ready1), 1);
    check("idle_valid0", int'(out_valid0), 0);
    check("idle_valid1", int'(out_valid1), 0);
    check("idle_code0", int'(out_code0), 0);
    check("idle_last0", int'(out_last0), 0);
    check("idle_count0", int'(bit_count0), exp_cnt);
    check("idle_count1", int'(bit_count1), exp_cnt);
  endtask

  // Present one vector and follow its whole emission against the reference
  // order lists; called at #1 after a rising edge with both DUTs idle.
  task automatic run_vector(input logic [15:0] vec, input int exp_cnt,
                            input int exp_f0, input int exp_f1,
                            input int stall_first, input bit rand_stall,
                            input bit hold_valid, input logic [15:0] busy_vec);
    int q0[$];
    int q1[$];
    int n;
    int k;
    int cyc;
    for (int i = 0; i < 16; i++)  if (vec[i]) q0.push_back(i);
    for (int i = 15; i >= 0; i--) if (vec[i]) q1.push_back(i);
    n = q0.size();
    check("accept_ready0", int'(in_ready0), 1);
    check("accept_ready1", int'(in_ready1), 1);
    in_vec    = vec;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    if (hold_valid) in_vec = busy_vec;
    else            in_valid = 1'b0;
    if (n == 0) begin
      check("zero_err0", int'(zero_err0), 1);
      check("zero_err1", int'(zero_err1), 1);
      check_idle(0);
      @(posedge clk); #1;
      check("zero_err_clr0", int'(zero_err0), 0);
      check("zero_err_clr1", int'(zero_err1), 0);
      check("zero_noval0", int'(out_valid0), 0);
      $display("vector %h: zero vector, zero_err pulse checked", vec);
      return;
    end
    k = 0;
    cyc = 0;
    while (k < n && cyc < 300) begin
      check("emit_valid0", int'(out_valid0), 1);
      check("emit_valid1", int'(out_valid1), 1);
      check("emit_busy0", int'(in_ready0), 0);
      check("emit_busy1", int'(in_ready1), 0);
      check("code_lsb", int'(out_code0), q0[k]);
      check("code_msb", int'(out_code1), q1[k]);
      check("last_lsb", int'(out_last0), (k == n - 1) ? 1 : 0);
      check("last_msb", int'(out_last1), (k == n - 1) ? 1 : 0);
      check("count_lsb", int'(bit_count0), exp_cnt);
      check("count_msb", int'(bit_count1), exp_cnt);
      check("emit_nozero", int'(zero_err0), 0);
      if (cyc == 0 && exp_f0 >= 0) begin
        check("first_lsb", int'(out_code0), exp_f0);
        check("first_msb", int'(out_code1), exp_f1);
      end
      if (cyc < stall_first)  out_ready = 1'b0;
      else if (rand_stall)    out_ready = ($urandom_range(0, 2) != 0);
      else                    out_ready = 1'b1;
      @(posedge clk); #1;
      if (out_ready) k++;
      cyc++;
    end
    if (k < n) check("emit_timeout", k, n);
    out_ready = 1'b0;
    check_idle(exp_cnt);
    $display("vector %h: %0d codes in %0d cycles, bit_count %0d", vec, n, cyc, exp_cnt);
  endtask

  vec_rec_t tbl[8];

  initial begin
    rst       = 1'b1;
    in_vec    = 16'd0;
    in_valid  = 1'b0;
    out_ready = 1'b0;

    tbl[0] = '{16'h4C08, 4,  3, 14, 0};
    tbl[1] = '{16'h0005, 2,  0,  2, 3};
    tbl[2] = '{16'h0000, 0,  0,  0, 0};
    tbl[3] = '{16'hFFFF, 16, 0, 15, 0};
    tbl[4] = '{16'h0001, 1,  0,  0, 2};
    tbl[5] = '{16'h8000, 1, 15, 15, 0};
    tbl[6] = '{16'hA5A5, 8,  0, 15, 1};
    tbl[7] = '{16'h0000, 0,  0,  0, 0};

    // Reset state, observed while reset is held
    #2;
    check("rst_ready", int'(in_ready0), 1);
    check("rst_valid", int'(out_valid0), 0);
    check("rst_code", int'(out_code0), 0);
    check("rst_last", int'(out_last0), 0);
    check("rst_count", int'(bit_count0), 0);
    check("rst_zero_err", int'(zero_err0), 0);
    $display("reset state checked");
    #21 rst = 1'b0;
    @(posedge clk); #1;

    // Table-driven vectors
    for (int t = 0; t < 8; t++) begin
      run_vector(tbl[t].vec, tbl[t].exp_cnt, tbl[t].exp_first_lsb,
                 tbl[t].exp_first_msb, tbl[t].stall_first, 1'b0, 1'b0, 16'd0);
    end

    // in_valid held with another vector while busy; that vector must be taken
    // on the first IDLE cycle (run_vector starts with in_valid already high)
    run_vector(16'h8001, 2, 0, 15, 0, 1'b0, 1'b1, 16'h0F30);
    run_vector(16'h0F30, 6, 4, 11, 0, 1'b0, 1'b0, 16'd0);

    // Asynchronous reset after the second code of 16'h4C08
    in_vec    = 16'h4C08;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("pre_rst_code_a", int'(out_code0), 3);
    @(posedge clk); #1;
    check("pre_rst_code_b", int'(out_code0), 10);
    @(posedge clk); #1;
    check("pre_rst_valid", int'(out_valid0), 1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_valid0", int'(out_valid0), 0);
    check("mid_rst_valid1", int'(out_valid1), 0);
    check("mid_rst_ready", int'(in_ready0), 1);
    check("mid_rst_count", int'(bit_count0), 0);
    check("mid_rst_code", int'(out_code0), 0);
    @(posedge clk); #2;
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      check("post_rst_valid0", int'(out_valid0), 0);
      check("post_rst_valid1", int'(out_valid1), 0);
      check("post_rst_ready", int'(in_ready0), 1);
    end
    out_ready = 1'b0;
    $display("reset mid-emission checked");

    // Randomized vectors with random backpressure
    for (int r = 0; r < 40; r++) begin
      logic [15:0] v;
      v = 16'($urandom & $urandom);
      if ($urandom_range(0, 9) == 0) v = 16'd0;
      if ($urandom_range(0, 9) == 0) v = 16'($urandom);
      run_vector(v, $countones(v), -1, -1, int'($urandom_range(0, 2)), 1'b1, 1'b0, 16'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
